// File: rtl/rx_byte_packer_pkg.sv
// Shared receive-path definitions for pcie_rx: default geometry, pointer sizing and gen codes.
package pcie_rx_pkg;

   localparam int IN_BYTES_DEF  = 64;
   localparam int OUT_BYTES_DEF = 16;
   localparam int BUF_BYTES_DEF = 128;

   localparam logic [2:0] GEN1 = 3'd1;
   localparam logic [2:0] GEN2 = 3'd2;
   localparam logic [2:0] GEN3 = 3'd3;
   localparam logic [2:0] GEN4 = 3'd4;
   localparam logic [2:0] GEN5 = 3'd5;

   typedef enum logic {
      OUT_PARTIAL,
      OUT_READY
   } outView_e;

   function automatic int ptrWidth(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rx_byte_packer_popcount.sv
// Combinational population count of a 64-bit lane/byte mask.
module popcount_64 (
   input  logic [63:0] mask_i,
   output logic [6:0]  count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 64; i++) begin
         count_o = count_o + 7'(mask_i[i]);
      end
   end

endmodule

// File: rtl/rx_byte_packer.sv
// Packs variable-width receive beats into a circular byte buffer and emits fixed-width chunks.
// Optional feature: define RX_PACKER_OVF_CNT_EN to add the saturating dropped-beat counter ovf_cnt.
module rx_byte_packer
   import pcie_rx_pkg::*;
#(
   parameter int IN_BYTES  = IN_BYTES_DEF,
   parameter int OUT_BYTES = OUT_BYTES_DEF,
   parameter int BUF_BYTES = BUF_BYTES_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       linkup,
   input  logic                       w,
   input  logic [IN_BYTES-1:0]        valid,
   input  logic [IN_BYTES*8-1:0]      data_in,
   output logic [OUT_BYTES*8-1:0]     out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overflow,
   output logic [$clog2(BUF_BYTES):0] level
`ifdef RX_PACKER_OVF_CNT_EN
   ,
   output logic [15:0]                ovf_cnt
`endif
);

   localparam int PW = ptrWidth(BUF_BYTES);
   localparam int LW = PW + 1;
   localparam int IW = ptrWidth(IN_BYTES);

   logic [PW-1:0]          wrPtr_q, wrPtr_d;
   logic [PW-1:0]          rdPtr_q, rdPtr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   overflow_q, overflow_d;
   logic [BUF_BYTES*8-1:0] memFlat;
   logic [63:0]            validExt;
   logic [6:0]             maskCount;
   logic [6:0]             nIn;
   logic [LW:0]            freeSpace;
   logic                   pop;
   logic                   accept;
   logic                   doWrite;
   logic                   reject;
   outView_e               outView;

   assign validExt = 64'(valid);

   popcount_64 uCount (
      .mask_i  (validExt),
      .count_o (maskCount)
   );

   assign nIn       = w ? maskCount : 7'd0;
   assign outView   = (level_q >= LW'(OUT_BYTES)) ? OUT_READY : OUT_PARTIAL;
   assign out_valid = (outView == OUT_READY);
   assign pop       = out_valid & out_ready;

   // A same-cycle pop frees a chunk of space that the incoming beat may use.
   assign freeSpace = (LW+1)'(BUF_BYTES) - {1'b0, level_q} + (pop ? (LW+1)'(OUT_BYTES) : '0);
   assign accept    = ((LW+1)'(nIn) <= freeSpace);
   assign doWrite   = linkup & accept & (nIn != 7'd0);
   assign reject    = linkup & ~accept;

   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (!linkup) begin
         wrPtr_d    = '0;
         rdPtr_d    = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (doWrite) wrPtr_d = wrPtr_q + PW'(nIn);
         if (pop) rdPtr_d = rdPtr_q + PW'(OUT_BYTES);
         level_d = level_q + (doWrite ? LW'(nIn) : '0) - (pop ? LW'(OUT_BYTES) : '0);
         if (reject) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Each slot selects its own byte lane by its distance from the write pointer.
   for (genvar i = 0; i < BUF_BYTES; i++) begin : gSlot
      logic [PW-1:0] offset;
      logic [7:0]    slot_q;
      assign offset = PW'(i) - wrPtr_q;
      always_ff @(posedge clk) begin
         if (doWrite && (LW'(offset) < LW'(nIn))) begin
            slot_q <= data_in[8*offset[IW-1:0] +: 8];
         end
      end
      assign memFlat[8*i +: 8] = slot_q;
   end

   for (genvar j = 0; j < OUT_BYTES; j++) begin : gRead
      logic [PW-1:0] idx;
      assign idx = rdPtr_q + PW'(j);
      assign out_data[8*j +: 8] = memFlat[8*idx +: 8];
   end

`ifdef RX_PACKER_OVF_CNT_EN
   logic [15:0] ovfCnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovfCnt_q <= '0;
      end else if (!linkup) begin
         ovfCnt_q <= '0;
      end else if (reject && (ovfCnt_q != 16'hFFFF)) begin
         ovfCnt_q <= ovfCnt_q + 16'd1;
      end
   end

   assign ovf_cnt = ovfCnt_q;
`endif

   assign overflow = overflow_q;
   assign level    = level_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Self-checking bench for rx_byte_packer: byte-queue reference model plus directed scenarios.
// Build with RX_PACKER_OVF_CNT_EN defined to also cover ovf_cnt.
module tb_rx_byte_packer;

   localparam int IN_BYTES  = 64;
   localparam int OUT_BYTES = 16;
   localparam int BUF_BYTES = 128;
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   linkup;
   logic                   w;
   logic                   out_ready;
   logic [IN_BYTES-1:0]    valid;
   logic [IN_BYTES*8-1:0]  data_in;
   logic [OUT_BYTES*8-1:0] out_data;
   logic                   out_valid;
   logic                   overflow;
   logic [7:0]             level;
`ifdef RX_PACKER_OVF_CNT_EN
   logic [15:0]            ovf_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] modelQ[$];
   bit         modelOvf;
   int         modelCnt;
   int         modelWr;

   always #5 clk = ~clk;

   rx_byte_packer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .linkup    (linkup),
      .w         (w),
      .valid     (valid),
      .data_in   (data_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .level     (level)
`ifdef RX_PACKER_OVF_CNT_EN
      ,
      .ovf_cnt   (ovf_cnt)
`endif
   );

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic [511:0] makeBeat(input int base);
      logic [511:0] b;
      b = '0;
      for (int k = 0; k < IN_BYTES; k++) b[8*k +: 8] = 8'(base + k);
      return b;
   endfunction

   function automatic logic [127:0] modelChunk();
      logic [127:0] c;
      c = '0;
      for (int j = 0; j < OUT_BYTES; j++) c[8*j +: 8] = modelQ[j];
      return c;
   endfunction

   // Reference model: the buffer is just a FIFO of bytes; pop first, then append if it fits.
   always @(posedge clk or negedge reset_n) begin
      int n;
      int room;
      bit doPop;
      if (!reset_n) begin
         modelQ.delete();
         modelOvf = 1'b0;
         modelCnt = 0;
         modelWr  = 0;
      end else begin
         n     = w ? $countones(valid) : 0;
         doPop = (modelQ.size() >= OUT_BYTES) && out_ready;
         if (!linkup) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelCnt = 0;
            modelWr  = 0;
         end else begin
            room = BUF_BYTES - modelQ.size() + (doPop ? OUT_BYTES : 0);
            if (doPop) repeat (OUT_BYTES) void'(modelQ.pop_front());
            if (n <= room) begin
               for (int k = 0; k < n; k++) modelQ.push_back(data_in[8*k +: 8]);
               modelWr = (modelWr + n) % BUF_BYTES;
            end else begin
               modelOvf = 1'b1;
               if (modelCnt < 65535) modelCnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("level", 128'(level), 128'(modelQ.size()));
         checkOutput("out_valid", 128'(out_valid), 128'(modelQ.size() >= OUT_BYTES));
         checkOutput("overflow", 128'(overflow), 128'(modelOvf));
         if (modelQ.size() >= OUT_BYTES) checkOutput("out_data", out_data, modelChunk());
`ifdef RX_PACKER_OVF_CNT_EN
         checkOutput("ovf_cnt", 128'(ovf_cnt), 128'(modelCnt));
`endif
      end
   end

   task automatic applyStimulus(input bit wIn, input logic [63:0] validIn, input logic [511:0] dataIn,
                                input bit readyIn, input bit linkIn);
      @(negedge clk);
      w         = wIn;
      valid     = validIn;
      data_in   = dataIn;
      out_ready = readyIn;
      linkup    = linkIn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      linkup    = 1'b1;
      w         = 1'b0;
      valid     = '0;
      data_in   = '0;
      out_ready = 1'b0;
      #2;
      checkOutput("rst_level", 128'(level), 128'd0);
      checkOutput("rst_valid", 128'(out_valid), 128'd0);
      checkOutput("rst_ovf", 128'(overflow), 128'd0);
      #20;
      reset_n = 1'b1;

      // Gen1 x4: four 4-byte beats make exactly one chunk.
      for (int b = 0; b < 4; b++) applyStimulus(1'b1, 64'hF, makeBeat(4*b), 1'b1, 1'b1);
      checkOutput("g1_level16", 128'(level), 128'd16);
      checkOutput("g1_valid", 128'(out_valid), 128'd1);
      checkOutput("g1_data", out_data, 128'h0f0e0d0c0b0a09080706050403020100);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("g1_level0", 128'(level), 128'd0);
      checkOutput("g1_valid0", 128'(out_valid), 128'd0);

      // Gen3 x16: fill to 128, empty-mask write is a no-op, third full beat is dropped.
      applyStimulus(1'b1, ALL_ONES, makeBeat(8'h40), 1'b0, 1'b1);
      checkOutput("g3_level64", 128'(level), 128'd64);
      applyStimulus(1'b1, ALL_ONES, makeBeat(8'h80), 1'b0, 1'b1);
      checkOutput("g3_level128", 128'(level), 128'd128);
      applyStimulus(1'b1, 64'h0, makeBeat(0), 1'b0, 1'b1);
      checkOutput("g3_noop_ovf", 128'(overflow), 128'd0);
      applyStimulus(1'b1, ALL_ONES, makeBeat(8'hC0), 1'b0, 1'b1);
      checkOutput("g3_ovf", 128'(overflow), 128'd1);
      checkOutput("g3_level_hold", 128'(level), 128'd128);
      checkOutput("g3_data", out_data, 128'h4f4e4d4c4b4a49484746454443424140);
`ifdef RX_PACKER_OVF_CNT_EN
      checkOutput("g3_ovf_cnt", 128'(ovf_cnt), 128'd1);
`endif

      // Link drop clears everything and ignores the write in that cycle.
      applyStimulus(1'b1, ALL_ONES, makeBeat(0), 1'b0, 1'b0);
      checkOutput("ld_level", 128'(level), 128'd0);
      checkOutput("ld_ovf", 128'(overflow), 128'd0);
      checkOutput("ld_valid", 128'(out_valid), 128'd0);
`ifdef RX_PACKER_OVF_CNT_EN
      checkOutput("ld_ovf_cnt", 128'(ovf_cnt), 128'd0);
`endif

      // Full buffer: a pop in the same cycle makes room for a 16-byte beat.
      applyStimulus(1'b1, ALL_ONES, makeBeat(0), 1'b0, 1'b1);
      applyStimulus(1'b1, ALL_ONES, makeBeat(64), 1'b0, 1'b1);
      applyStimulus(1'b1, 64'hFFFF, makeBeat(128), 1'b1, 1'b1);
      checkOutput("pw_level", 128'(level), 128'd128);
      checkOutput("pw_ovf", 128'(overflow), 128'd0);
      checkOutput("pw_data", out_data, 128'h1f1e1d1c1b1a19181716151413121110);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

      // Wrap-around: 120 in, 112 out, 32 in lands across the buffer end.
      applyStimulus(1'b1, ALL_ONES, makeBeat(0), 1'b0, 1'b1);
      applyStimulus(1'b1, 64'h00FF_FFFF_FFFF_FFFF, makeBeat(64), 1'b0, 1'b1);
      checkOutput("wr_level120", 128'(level), 128'd120);
      repeat (7) applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("wr_level8", 128'(level), 128'd8);
      applyStimulus(1'b1, 64'hFFFF_FFFF, makeBeat(120), 1'b0, 1'b1);
      checkOutput("wr_level40", 128'(level), 128'd40);
      checkOutput("wr_ptr", 128'(dut.wrPtr_q), 128'd24);
      checkOutput("wr_ptr_model", 128'(dut.wrPtr_q), 128'(modelWr));
      checkOutput("wr_data_a", out_data, 128'h7f7e7d7c7b7a79787776757473727170);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("wr_data_b", out_data, 128'h8f8e8d8c8b8a89888786858483828180);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("wr_level_tail", 128'(level), 128'd8);
      checkOutput("wr_valid_tail", 128'(out_valid), 128'd0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

      // Async reset mid-stream with level 48 and overflow set.
      applyStimulus(1'b1, ALL_ONES, makeBeat(0), 1'b0, 1'b1);
      applyStimulus(1'b1, ALL_ONES, makeBeat(64), 1'b0, 1'b1);
      applyStimulus(1'b1, ALL_ONES, makeBeat(128), 1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("ar_level48", 128'(level), 128'd48);
      checkOutput("ar_ovf_pre", 128'(overflow), 128'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("ar_level", 128'(level), 128'd0);
      checkOutput("ar_valid", 128'(out_valid), 128'd0);
      checkOutput("ar_ovf", 128'(overflow), 128'd0);
`ifdef RX_PACKER_OVF_CNT_EN
      checkOutput("ar_ovf_cnt", 128'(ovf_cnt), 128'd0);
`endif
      #4;
      reset_n = 1'b1;
      applyStimulus(1'b1, 64'hFF, makeBeat(8'h20), 1'b0, 1'b1);
      checkOutput("ar_resume", 128'(level), 128'd8);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
